// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// ---------------------------------------------------------------------------
// Shares the single register-file write port among three producers:
//   req 0 = ALU result, req 1 = load unit, req 2 = link/PC write.
// Round-robin arbitration with a valid/ready handshake per requester, feeding
// a one-entry registered write command that honours a downstream stall.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-low reset
//   req_valid  in   [NREQ]          per-requester write request
//   req_addr   in   [NREQ*ADDR_W]   destination, requester i at [i*ADDR_W +: ADDR_W]
//   req_data   in   [NREQ*DATA_W]   write data, packed the same way
//   req_ready  out  [NREQ]          one-hot or zero acceptance (combinational)
//   wr_stall   in   downstream cannot take a write this cycle
//   wr_en      out  registered write strobe
//   wr_addr    out  registered destination register
//   wr_data    out  registered write data
//   wr_src     out  index of the requester that produced the current command
//
// Optional build macro REGWR_ARB_STATS_EN adds:
//   stat_clr     in   synchronous clear of all statistics counters
//   stat_grant0  out  accepted transfers from requester 0 (saturating, 16 bit)
//   stat_grant1  out  accepted transfers from requester 1
//   stat_grant2  out  accepted transfers from requester 2
//   stat_wait    out  cycles with some request pending but no transfer
// ---------------------------------------------------------------------------
module regfile_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREQ   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     wr_stall,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  output logic [1:0]               wr_src
`ifdef REGWR_ARB_STATS_EN
  ,
  input  logic                     stat_clr,
  output logic [15:0]              stat_grant0,
  output logic [15:0]              stat_grant1,
  output logic [15:0]              stat_grant2,
  output logic [15:0]              stat_wait
`endif
);

  // The rotation tables below are written for exactly three requesters.
  if (NREQ != 3) begin : g_nreq_check
    $error("regfile_write_arbiter supports only NREQ == 3");
  end

  // Saturating 16-bit increment shared by the statistics counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] val, input logic inc);
    if (inc && (val != 16'hFFFF)) begin
      sat_inc16 = val + 16'd1;
    end else begin
      sat_inc16 = val;
    end
  endfunction

  logic              wr_en_q,   wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic [1:0]        wr_src_q,  wr_src_d;
  logic [1:0]        last_q,    last_d;

  logic [ADDR_W-1:0] addr_arr_s [NREQ];
  logic [DATA_W-1:0] data_arr_s [NREQ];
  logic [1:0]        ord0_s, ord1_s, ord2_s;
  logic [1:0]        cand_s;
  logic              cand_vld_s;
  logic              free_s;
  logic              xfer_s;

  // Unpack the flat request buses into per-requester arrays.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      addr_arr_s[i] = req_addr[i*ADDR_W +: ADDR_W];
      data_arr_s[i] = req_data[i*DATA_W +: DATA_W];
    end
  end

  // Search order starts just after the last granted requester.
  always_comb begin
    case (last_q)
      2'd0: begin ord0_s = 2'd1; ord1_s = 2'd2; ord2_s = 2'd0; end
      2'd1: begin ord0_s = 2'd2; ord1_s = 2'd0; ord2_s = 2'd1; end
      2'd2: begin ord0_s = 2'd0; ord1_s = 2'd1; ord2_s = 2'd2; end
      default: begin ord0_s = 2'd0; ord1_s = 2'd1; ord2_s = 2'd2; end
    endcase
  end

  // First valid requester in rotation order is the candidate.
  always_comb begin
    if (req_valid[ord0_s]) begin
      cand_s     = ord0_s;
      cand_vld_s = 1'b1;
    end else if (req_valid[ord1_s]) begin
      cand_s     = ord1_s;
      cand_vld_s = 1'b1;
    end else if (req_valid[ord2_s]) begin
      cand_s     = ord2_s;
      cand_vld_s = 1'b1;
    end else begin
      cand_s     = 2'd0;
      cand_vld_s = 1'b0;
    end
  end

  // The output slot is free unless it holds a command that is being stalled.
  // rst gates ready so nothing is accepted while reset is asserted.
  always_comb begin
    free_s = ~wr_en_q | ~wr_stall;
    xfer_s = cand_vld_s & free_s & rst;
    if (xfer_s) begin
      req_ready = {{(NREQ-1){1'b0}}, 1'b1} << cand_s;
    end else begin
      req_ready = {NREQ{1'b0}};
    end
  end

  // Next command: load on transfer, drain when free, hold while stalled.
  always_comb begin
    wr_en_d   = wr_en_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_src_d  = wr_src_q;
    last_d    = last_q;
    if (xfer_s) begin
      // Writes to r0 are swallowed, but the fields stay visible for debug.
      wr_en_d   = (addr_arr_s[cand_s] != {ADDR_W{1'b0}});
      wr_addr_d = addr_arr_s[cand_s];
      wr_data_d = data_arr_s[cand_s];
      wr_src_d  = cand_s;
      last_d    = cand_s;
    end else if (free_s) begin
      wr_en_d   = 1'b0;
    end else begin
      wr_en_d   = wr_en_q;
    end
  end

  // Command register and round-robin pointer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= {ADDR_W{1'b0}};
      wr_data_q <= {DATA_W{1'b0}};
      wr_src_q  <= 2'd0;
      last_q    <= 2'd2;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_src_q  <= wr_src_d;
      last_q    <= last_d;
    end
  end

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign wr_src  = wr_src_q;

`ifdef REGWR_ARB_STATS_EN
  logic [15:0] stat_grant0_q, stat_grant0_d;
  logic [15:0] stat_grant1_q, stat_grant1_d;
  logic [15:0] stat_grant2_q, stat_grant2_d;
  logic [15:0] stat_wait_q,   stat_wait_d;

  // Counter next-state: clear wins over any increment in the same cycle.
  always_comb begin
    if (stat_clr) begin
      stat_grant0_d = 16'd0;
      stat_grant1_d = 16'd0;
      stat_grant2_d = 16'd0;
      stat_wait_d   = 16'd0;
    end else begin
      stat_grant0_d = sat_inc16(stat_grant0_q, xfer_s && (cand_s == 2'd0));
      stat_grant1_d = sat_inc16(stat_grant1_q, xfer_s && (cand_s == 2'd1));
      stat_grant2_d = sat_inc16(stat_grant2_q, xfer_s && (cand_s == 2'd2));
      stat_wait_d   = sat_inc16(stat_wait_q, (|req_valid) && !xfer_s);
    end
  end

  // Statistics counter registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_grant0_q <= 16'd0;
      stat_grant1_q <= 16'd0;
      stat_grant2_q <= 16'd0;
      stat_wait_q   <= 16'd0;
    end else begin
      stat_grant0_q <= stat_grant0_d;
      stat_grant1_q <= stat_grant1_d;
      stat_grant2_q <= stat_grant2_d;
      stat_wait_q   <= stat_wait_d;
    end
  end

  assign stat_grant0 = stat_grant0_q;
  assign stat_grant1 = stat_grant1_q;
  assign stat_grant2 = stat_grant2_q;
  assign stat_wait   = stat_wait_q;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Testbench for regfile_write_arbiter: directed stimulus pushes expected
// write commands into a scoreboard queue; a negedge monitor pops one entry
// each time the DUT presents a command the register file consumes.
module tb_regfile_write_arbiter;

  typedef struct packed {
    logic [1:0]  src;
    logic [4:0]  addr;
    logic [31:0] data;
  } cmd_t;

  logic        clk;
  logic        rst;
  logic [2:0]  req_valid;
  logic [14:0] req_addr;
  logic [95:0] req_data;
  logic [2:0]  req_ready;
  logic        wr_stall;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [1:0]  wr_src;
`ifdef REGWR_ARB_STATS_EN
  logic        stat_clr;
  logic [15:0] stat_grant0, stat_grant1, stat_grant2, stat_wait;
`endif

  cmd_t sb[$];
  int   total = 0;
  int   bad   = 0;

  regfile_write_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .wr_stall  (wr_stall),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_src    (wr_src)
`ifdef REGWR_ARB_STATS_EN
    ,
    .stat_clr    (stat_clr),
    .stat_grant0 (stat_grant0),
    .stat_grant1 (stat_grant1),
    .stat_grant2 (stat_grant2),
    .stat_wait   (stat_wait)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [4:0] a, input logic [31:0] d);
    req_addr[i*5 +: 5]   = a;
    req_data[i*32 +: 32] = d;
  endtask

  task automatic expect_cmd(input logic [1:0] s, input logic [4:0] a, input logic [31:0] d);
    cmd_t c;
    c.src  = s;
    c.addr = a;
    c.data = d;
    sb.push_back(c);
  endtask

  // Monitor: a command is consumed when wr_en is high and not stalled.
  always @(negedge clk) begin
    if (rst && wr_en && !wr_stall) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_cmd: got src=%0d addr=%0d data=%0h with empty scoreboard",
                 wr_src, wr_addr, wr_data);
      end else begin
        cmd_t e;
        e = sb.pop_front();
        chk("mon_src",  32'(wr_src),  32'(e.src));
        chk("mon_addr", 32'(wr_addr), 32'(e.addr));
        chk("mon_data", wr_data,      e.data);
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b0;
    req_valid = 3'b111;
    req_addr  = 15'd0;
    req_data  = 96'd0;
    wr_stall  = 1'b0;
`ifdef REGWR_ARB_STATS_EN
    stat_clr  = 1'b0;
`endif
    set_req(0, 5'd5, 32'hA);
    set_req(1, 5'd6, 32'hB);
    set_req(2, 5'd7, 32'hC);

    // Reset state with all requests pending.
    step();
    step();
    chk("rst_ready",   32'(req_ready), 32'd0);
    chk("rst_wr_en",   32'(wr_en),     32'd0);
    chk("rst_wr_addr", 32'(wr_addr),   32'd0);
    chk("rst_wr_data", wr_data,        32'd0);
    chk("rst_wr_src",  32'(wr_src),    32'd0);

    // Release reset: rotation 0,1,2,0 at full throughput.
    rst = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] s;
      s = 2'(k % 3);
      chk("rr_ready", 32'(req_ready), 32'(3'b001 << s));
      expect_cmd(s, 5'(5 + s), 32'(32'hA + 32'(s)));
      step();
    end
    req_valid = 3'b000;
    step();
    chk("rr_drain_wr_en", 32'(wr_en), 32'd0);

    // Stall: grant req 1 then hold for three cycles.
    set_req(1, 5'd9, 32'hDEAD_BEEF);
    req_valid = 3'b010;
    #1;
    chk("stall_grant_ready", 32'(req_ready), 32'b010);
    expect_cmd(2'd1, 5'd9, 32'hDEAD_BEEF);
    step();
    req_valid = 3'b111;
    wr_stall  = 1'b1;
    #1;
    chk("stall_ready0", 32'(req_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_wr_en",   32'(wr_en),     32'd1);
      chk("stall_wr_addr", 32'(wr_addr),   32'd9);
      chk("stall_wr_data", wr_data,        32'hDEAD_BEEF);
      chk("stall_ready",   32'(req_ready), 32'd0);
    end
    wr_stall = 1'b0;
    #1;
    chk("post_stall_ready", 32'(req_ready), 32'b100);
    expect_cmd(2'd2, 5'd7, 32'hC);
    step();
    req_valid = 3'b000;
    step();

    // Address 0: accepted, no write strobe, fields loaded.
    set_req(2, 5'd0, 32'h1234);
    req_valid = 3'b100;
    #1;
    chk("a0_ready", 32'(req_ready), 32'b100);
    step();
    req_valid = 3'b000;
    #1;
    chk("a0_wr_en",   32'(wr_en),   32'd0);
    chk("a0_wr_src",  32'(wr_src),  32'd2);
    chk("a0_wr_addr", 32'(wr_addr), 32'd0);
    chk("a0_wr_data", wr_data,      32'h1234);
    req_valid = 3'b011;
    #1;
    chk("a0_next_ready", 32'(req_ready), 32'b001);
    expect_cmd(2'd0, 5'd5, 32'hA);
    step();
    req_valid = 3'b000;
    step();

    // Async reset while a command is stalled.
    set_req(1, 5'd6, 32'hB);
    req_valid = 3'b010;
    #1;
    chk("ar_grant_ready", 32'(req_ready), 32'b010);
    expect_cmd(2'd1, 5'd6, 32'hB);
    step();
    req_valid = 3'b000;
    wr_stall  = 1'b1;
    step();
    chk("ar_stalled_wr_en", 32'(wr_en), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_wr_en",  32'(wr_en),     32'd0);
    req_valid = 3'b111;
    #1;
    chk("ar_ready",  32'(req_ready), 32'd0);
    void'(sb.pop_back());   // discarded by reset
    wr_stall = 1'b0;
    step();
    rst = 1'b1;
    #1;
    chk("ar_restart_ready", 32'(req_ready), 32'b001);
    expect_cmd(2'd0, 5'd5, 32'hA);
    step();
    req_valid = 3'b000;
    step();
    step();

`ifdef REGWR_ARB_STATS_EN
    // Statistics: 10 grants to req 0 then 4 stalled wait cycles.
    stat_clr = 1'b1;
    step();
    stat_clr  = 1'b0;
    req_valid = 3'b001;
    for (int k = 0; k < 10; k++) begin
      set_req(0, 5'd3, 32'h100 + 32'(k));
      #1;
      expect_cmd(2'd0, 5'd3, 32'h100 + 32'(k));
      step();
    end
    wr_stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
    end
    req_valid = 3'b000;
    wr_stall  = 1'b0;
    step();
    chk("stat_grant0", 32'(stat_grant0), 32'd10);
    chk("stat_grant1", 32'(stat_grant1), 32'd0);
    chk("stat_grant2", 32'(stat_grant2), 32'd0);
    chk("stat_wait",   32'(stat_wait),   32'd4);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    chk("stat_clr_g0",   32'(stat_grant0), 32'd0);
    chk("stat_clr_wait", 32'(stat_wait),   32'd0);
    step();
`endif

    step();
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
